// File: rtl/arc4_engine_if.sv
// ARC4 engine bus: start/ready handshake, key, and S/CT/PT RAM ports.
// Ports: en, key in; rdy, valid out; s_*, ct_*, pt_* RAM buses.
interface arc4_engine_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [KEY_BYTES*8-1:0] key;
  logic                   valid;
  logic [7:0]             s_addr;
  logic [7:0]             s_wrdata;
  logic                   s_wren;
  logic [7:0]             s_rddata;
  logic [7:0]             ct_addr;
  logic [7:0]             ct_rddata;
  logic [7:0]             pt_addr;
  logic [7:0]             pt_wrdata;
  logic                   pt_wren;

  modport master (
    output en, key, s_rddata, ct_rddata,
    input  rdy, valid, s_addr, s_wrdata, s_wren,
    input  ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    input  en, key, s_rddata, ct_rddata,
    output rdy, valid, s_addr, s_wrdata, s_wren,
    output ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_engine.sv
// ARC4 decrypt engine over external S/CT/PT RAMs, optional printable check.
// Ports: clk, rst_n (async low); bus = arc4_engine_if.slave (handshake+RAMs).
module arc4_engine #(
  parameter int         KEY_BYTES  = 3,
  parameter bit         CHECK_MODE = 1'b0,
  parameter logic [7:0] PRINT_LO   = 8'h20,
  parameter logic [7:0] PRINT_HI   = 8'h7E
) (
  input logic         clk,
  input logic         rst_n,
  arc4_engine_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INIT,
    KSA_RI, KSA_RJ, KSA_WI, KSA_WJ,
    LEN_RD, LEN_WR,
    P_RI, P_RJ, P_WI, P_WJ, P_RP, P_OUT,
    FINISH
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] ct_q, ct_d;
  logic [4:0] kidx_q, kidx_d;
  logic       ok_q, ok_d;
  logic       valid_q, valid_d;
  logic [7:0] kb_q [32];
  logic [7:0] key_b [32];
  logic       load_key;
  logic [7:0] p;

  // Key bytes re-ordered so kb_q[n] is key byte n (MSB first on the port).
  always_comb begin
    for (int b = 0; b < 32; b++) key_b[b] = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      key_b[b] = bus.key[(KEY_BYTES-1-b)*8 +: 8];
  end

  assign load_key  = (state_q == IDLE) && bus.en;
  assign bus.valid = valid_q;
  assign p         = bus.s_rddata ^ ct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ct_q    <= '0;
      kidx_q  <= '0;
      ok_q    <= 1'b0;
      valid_q <= 1'b0;
      for (int b = 0; b < 32; b++) kb_q[b] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ct_q    <= ct_d;
      kidx_q  <= kidx_d;
      ok_q    <= ok_d;
      valid_q <= valid_d;
      if (load_key)
        for (int b = 0; b < 32; b++) kb_q[b] <= key_b[b];
    end
  end

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    len_d         = len_q;
    si_d          = si_q;
    sj_d          = sj_q;
    ct_d          = ct_q;
    kidx_d        = kidx_q;
    ok_d          = ok_q;
    valid_d       = valid_q;
    bus.rdy       = 1'b0;
    bus.s_addr    = '0;
    bus.s_wrdata  = '0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = '0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = '0;
    bus.pt_wren   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          state_d = INIT;
          valid_d = 1'b0;
          ok_d    = 1'b0;
          i_d     = '0;
        end
      end
      INIT: begin
        bus.s_addr   = i_q;
        bus.s_wrdata = i_q;
        bus.s_wren   = 1'b1;
        i_d          = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = KSA_RI;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      KSA_RI: begin
        bus.s_addr = i_q;
        state_d    = KSA_RJ;
      end
      KSA_RJ: begin
        si_d       = bus.s_rddata;
        j_d        = j_q + bus.s_rddata + kb_q[kidx_q];
        bus.s_addr = j_d;
        state_d    = KSA_WI;
      end
      // Old S[i] is held in si_q, so i==j leaves S[i] intact.
      KSA_WI: begin
        bus.s_addr   = i_q;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
        state_d      = KSA_WJ;
      end
      KSA_WJ: begin
        bus.s_addr   = j_q;
        bus.s_wrdata = si_q;
        bus.s_wren   = 1'b1;
        i_d          = i_q + 8'd1;
        kidx_d       = (kidx_q == 5'(KEY_BYTES-1)) ? 5'd0 : kidx_q + 5'd1;
        state_d      = (i_q == 8'hFF) ? LEN_RD : KSA_RI;
      end
      LEN_RD: begin
        state_d = LEN_WR;
      end
      LEN_WR: begin
        len_d         = bus.ct_rddata;
        bus.pt_wrdata = bus.ct_rddata;
        bus.pt_wren   = 1'b1;
        i_d           = '0;
        j_d           = '0;
        k_d           = 8'd1;
        if (bus.ct_rddata == 8'd0) begin
          ok_d    = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = P_RI;
        end
      end
      P_RI: begin
        i_d        = i_q + 8'd1;
        bus.s_addr = i_d;
        state_d    = P_RJ;
      end
      P_RJ: begin
        si_d       = bus.s_rddata;
        j_d        = j_q + bus.s_rddata;
        bus.s_addr = j_d;
        state_d    = P_WI;
      end
      P_WI: begin
        sj_d         = bus.s_rddata;
        bus.s_addr   = i_q;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
        bus.ct_addr  = k_q;
        state_d      = P_WJ;
      end
      P_WJ: begin
        bus.s_addr   = j_q;
        bus.s_wrdata = si_q;
        bus.s_wren   = 1'b1;
        ct_d         = bus.ct_rddata;
        state_d      = P_RP;
      end
      P_RP: begin
        bus.s_addr = si_q + sj_q;
        state_d    = P_OUT;
      end
      P_OUT: begin
        if (CHECK_MODE && (p < PRINT_LO || p > PRINT_HI)) begin
          ok_d    = 1'b0;
          state_d = FINISH;
        end else begin
          bus.pt_addr   = k_q;
          bus.pt_wrdata = p;
          bus.pt_wren   = 1'b1;
          if (k_q == len_q) begin
            ok_d    = 1'b1;
            state_d = FINISH;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = P_RI;
          end
        end
      end
      FINISH: begin
        valid_d = ok_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_engine.sv
// Bench for arc4_engine: three configurations against a behavioural ARC4 model.
// Ports: none; drives three arc4_engine_if instances and RAM models.
module tb_arc4_engine;

  localparam logic [7:0] PLO = 8'h20;
  localparam logic [7:0] PHI = 8'h7E;
  localparam logic [7:0] MARK = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arc4_engine_if #(.KEY_BYTES(3)) b0 ();
  arc4_engine_if #(.KEY_BYTES(4)) b1 ();
  arc4_engine_if #(.KEY_BYTES(3)) b2 ();

  arc4_engine #(.KEY_BYTES(3), .CHECK_MODE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  arc4_engine #(.KEY_BYTES(4), .CHECK_MODE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  arc4_engine #(.KEY_BYTES(3), .CHECK_MODE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  logic [7:0] s_m  [3][256];
  logic [7:0] ct_m [3][256];
  logic [7:0] pt_m [3][256];
  logic [7:0] s_rd [3];
  logic [7:0] ct_rd [3];
  int ptw_cnt [3] = '{0, 0, 0};
  int idle_wr = 0;

  logic       bd_we = 1'b0;
  logic       bd_pt = 1'b0;
  int         bd_g = 0;
  logic [7:0] bd_a = '0;
  logic [7:0] bd_d = '0;

  assign b0.s_rddata  = s_rd[0];
  assign b1.s_rddata  = s_rd[1];
  assign b2.s_rddata  = s_rd[2];
  assign b0.ct_rddata = ct_rd[0];
  assign b1.ct_rddata = ct_rd[1];
  assign b2.ct_rddata = ct_rd[2];

  always @(posedge clk) begin
    s_rd[0]  <= s_m[0][b0.s_addr];
    s_rd[1]  <= s_m[1][b1.s_addr];
    s_rd[2]  <= s_m[2][b2.s_addr];
    ct_rd[0] <= ct_m[0][b0.ct_addr];
    ct_rd[1] <= ct_m[1][b1.ct_addr];
    ct_rd[2] <= ct_m[2][b2.ct_addr];
    if (b0.s_wren) s_m[0][b0.s_addr] <= b0.s_wrdata;
    if (b1.s_wren) s_m[1][b1.s_addr] <= b1.s_wrdata;
    if (b2.s_wren) s_m[2][b2.s_addr] <= b2.s_wrdata;
    if (b0.pt_wren) begin
      pt_m[0][b0.pt_addr] <= b0.pt_wrdata;
      ptw_cnt[0] <= ptw_cnt[0] + 1;
    end
    if (b1.pt_wren) begin
      pt_m[1][b1.pt_addr] <= b1.pt_wrdata;
      ptw_cnt[1] <= ptw_cnt[1] + 1;
    end
    if (b2.pt_wren) begin
      pt_m[2][b2.pt_addr] <= b2.pt_wrdata;
      ptw_cnt[2] <= ptw_cnt[2] + 1;
    end
    if (((b0.s_wren || b0.pt_wren) && b0.rdy) ||
        ((b1.s_wren || b1.pt_wren) && b1.rdy) ||
        ((b2.s_wren || b2.pt_wren) && b2.rdy))
      idle_wr <= idle_wr + 1;
    if (bd_we) begin
      if (bd_pt) pt_m[bd_g][bd_a] <= bd_d;
      else       ct_m[bd_g][bd_a] <= bd_d;
    end
  end

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(int g);
    case (g)
      0:       return b0.rdy;
      1:       return b1.rdy;
      default: return b2.rdy;
    endcase
  endfunction

  function automatic logic get_valid(int g);
    case (g)
      0:       return b0.valid;
      1:       return b1.valid;
      default: return b2.valid;
    endcase
  endfunction

  task automatic set_en(int g, logic v);
    case (g)
      0:       b0.en = v;
      1:       b1.en = v;
      default: b2.en = v;
    endcase
  endtask

  task automatic set_key(int g, input logic [7:0] kq[$]);
    case (g)
      0:       b0.key = {kq[0], kq[1], kq[2]};
      1:       b1.key = {kq[0], kq[1], kq[2], kq[3]};
      default: b2.key = {kq[0], kq[1], kq[2]};
    endcase
  endtask

  function automatic void bytes_of(input logic [255:0] v, input int n,
                                   output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(v[(n-1-i)*8 +: 8]);
  endfunction

  // ARC4 keystream straight from the algorithm definition.
  function automatic void arc4_ks(input logic [7:0] kq[$], input int n,
                                  output logic [7:0] ks[$]);
    int s [256];
    int j, t, x;
    for (int i = 0; i < 256; i++) s[i] = i;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + s[i] + int'(kq[i % kq.size()])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    ks.delete();
    x = 0; j = 0;
    for (int k = 0; k < n; k++) begin
      x = (x + 1) % 256;
      j = (j + s[x]) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
      ks.push_back(8'(s[(s[x] + s[j]) % 256]));
    end
  endfunction

  function automatic void expect_pt(input logic [7:0] kq[$],
                                    input logic [7:0] ct[$], input bit cm,
                                    output logic [7:0] ept [256],
                                    output logic ev, output int nwr);
    logic [7:0] ks[$];
    logic [7:0] pv;
    int L;
    L = int'(ct[0]);
    arc4_ks(kq, L, ks);
    for (int a = 0; a < 256; a++) ept[a] = MARK;
    ept[0] = ct[0];
    ev = 1'b1;
    nwr = 1;
    for (int k = 1; k <= L; k++) begin
      pv = ks[k-1] ^ ct[k];
      if (cm && (pv < PLO || pv > PHI)) begin
        ev = 1'b0;
        break;
      end
      ept[k] = pv;
      nwr++;
    end
  endfunction

  task automatic bd_wr(int g, logic pt, logic [7:0] a, logic [7:0] d);
    bd_g = g; bd_pt = pt; bd_a = a; bd_d = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic load(int g, input logic [7:0] ct[$]);
    for (int a = 0; a < ct.size(); a++) bd_wr(g, 1'b0, 8'(a), ct[a]);
    for (int a = 0; a < 256; a++) bd_wr(g, 1'b1, 8'(a), MARK);
  endtask

  // Start on the next edge, optionally poke en mid-run, wait for rdy.
  task automatic run(int g, input logic [7:0] kq[$], input int L,
                     input int poke);
    int cyc, bound;
    bound = 256 + 6*256 + 8*L + 4;
    set_key(g, kq);
    set_en(g, 1'b1);
    @(posedge clk); #1;
    set_en(g, 1'b0);
    chk("rdy_drop", 32'(get_rdy(g)), 32'd0);
    chk("valid_clr", 32'(get_valid(g)), 32'd0);
    cyc = 1;
    while (!get_rdy(g) && cyc < bound + 4) begin
      set_en(g, cyc == poke);
      @(posedge clk); #1;
      cyc++;
      if (poke > 0 && cyc == poke + 1)
        chk("en_ignored", 32'(get_rdy(g)), 32'd0);
    end
    set_en(g, 1'b0);
    chk("done_in_budget", 32'(get_rdy(g) && cyc <= bound), 32'd1);
  endtask

  task automatic verify(int g, input logic [7:0] kq[$],
                        input logic [7:0] ct[$], input bit cm,
                        input string tag, input int poke);
    logic [7:0] ept [256];
    logic ev;
    int nwr, w0;
    w0 = ptw_cnt[g];
    run(g, kq, int'(ct[0]), poke);
    expect_pt(kq, ct, cm, ept, ev, nwr);
    chk({tag, "_valid"}, 32'(get_valid(g)), 32'(ev));
    chk({tag, "_nwr"}, 32'(ptw_cnt[g] - w0), 32'(nwr));
    for (int a = 0; a < 256; a++)
      chk($sformatf("%s_pt%0d", tag, a), 32'(pt_m[g][a]), 32'(ept[a]));
  endtask

  initial begin
    logic [7:0] kkey[$], kwiki[$], kq[$], ct[$], ct1[$], ks[$];
    logic [71:0] pl;
    logic [39:0] pd;
    int cnt [256];
    int dups, L, bad;
    logic [7:0] pv;

    b0.en = 1'b0; b1.en = 1'b0; b2.en = 1'b0;
    b0.key = '0; b1.key = '0; b2.key = '0;
    bytes_of(256'h4B6579, 3, kkey);
    bytes_of(256'h57696B69, 4, kwiki);
    pl = "Plaintext";
    pd = "pedia";

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy0", 32'(b0.rdy), 32'd1);
    chk("rst_rdy1", 32'(b1.rdy), 32'd1);
    chk("rst_valid0", 32'(b0.valid), 32'd0);
    chk("rst_swren0", 32'(b0.s_wren), 32'd0);
    chk("rst_ptwren0", 32'(b0.pt_wren), 32'd0);
    chk("rst_saddr0", 32'(b0.s_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    bytes_of(256'h09BBF316E8D940AF0AD3, 10, ct1);
    load(0, ct1);
    verify(0, kkey, ct1, 1'b0, "key", 0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("plaintext%0d", i), 32'(pt_m[0][i+1]),
          32'(pl[(8-i)*8 +: 8]));

    bytes_of(256'h051021BF0420, 6, ct);
    load(1, ct);
    verify(1, kwiki, ct, 1'b1, "wiki", 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("pedia%0d", i), 32'(pt_m[1][i+1]),
          32'(pd[(4-i)*8 +: 8]));
    for (int v = 0; v < 256; v++) cnt[v] = 0;
    for (int a = 0; a < 256; a++) cnt[s_m[1][a]]++;
    dups = 0;
    for (int v = 0; v < 256; v++) if (cnt[v] != 1) dups++;
    chk("s_perm", 32'(dups), 32'd0);

    bytes_of(256'h09BBF377E8D940AF0AD3, 10, ct);
    load(2, ct);
    verify(2, kkey, ct, 1'b1, "abort", 0);
    chk("abort_valid", 32'(b2.valid), 32'd0);
    chk("abort_P", 32'(pt_m[2][1]), 32'h50);
    chk("abort_l", 32'(pt_m[2][2]), 32'h6C);
    chk("abort_k3", 32'(pt_m[2][3]), 32'(MARK));

    bytes_of(256'h00, 1, ct);
    load(0, ct);
    verify(0, kkey, ct, 1'b0, "len0", 200);
    chk("len0_valid", 32'(b0.valid), 32'd1);

    chk("pre_rst_valid1", 32'(b1.valid), 32'd1);
    set_key(0, kkey);
    set_en(0, 1'b1);
    @(posedge clk); #1;
    set_en(0, 1'b0);
    repeat (400) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(b0.rdy), 32'd1);
    chk("midrst_valid1", 32'(b1.valid), 32'd0);
    chk("midrst_swren", 32'(b0.s_wren), 32'd0);
    chk("midrst_ptwren", 32'(b0.pt_wren), 32'd0);
    chk("midrst_saddr", 32'(b0.s_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(0, ct1);
    verify(0, kkey, ct1, 1'b0, "rerun", 0);

    kq.delete();
    repeat (3) kq.push_back(8'($urandom));
    verify(0, kq, ct1, 1'b0, "b2b", 0);

    for (int r = 0; r < 4; r++) begin
      kq.delete();
      repeat (3) kq.push_back(8'($urandom));
      L = int'($urandom_range(1, 30));
      ct.delete();
      ct.push_back(8'(L));
      repeat (L) ct.push_back(8'($urandom));
      load(0, ct);
      verify(0, kq, ct, 1'b0, "rnd0", 0);

      kq.delete();
      repeat (4) kq.push_back(8'($urandom));
      L = int'($urandom_range(1, 30));
      arc4_ks(kq, L, ks);
      bad = (r % 2 == 1) ? int'($urandom_range(1, L)) : 0;
      ct.delete();
      ct.push_back(8'(L));
      for (int k = 1; k <= L; k++) begin
        pv = (k == bad) ? 8'($urandom_range(0, 31))
                        : 8'($urandom_range(32, 126));
        ct.push_back(pv ^ ks[k-1]);
      end
      load(1, ct);
      verify(1, kq, ct, 1'b1, "rnd1", 0);
    end

    chk("no_idle_wr", 32'(idle_wr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
